// File: rtl/sc_countdown_timer_pkg.sv
// sc_countdown_timer_pkg: shared state codes and default constants for the countdown timer.
package sc_countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        PAUSE   = 2'b10,
        EXPIRED = 2'b11
    } state_t;

    localparam int DATAWIDTH_DEF   = 8;
    localparam int INIT_VALUE_DEF  = 99;
    localparam int ADD_VALUE_DEF   = 10;
    localparam int PRESC_WIDTH_DEF = 26;
    localparam int PRESC_MAX_DEF   = 49_999_999;

endpackage

// File: rtl/sc_countdown_timer_prescaler.sv
// sc_prescaler_tick: enabled free-running divider that wraps at MAX and flags the wrapping cycle.
module sc_prescaler_tick #(
    parameter int WIDTH = 26,
    parameter int MAX   = 49_999_999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             term
);

    // term is combinational so the owner can register it alongside its own update
    assign term = en && !clr && (count == WIDTH'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= term ? '0 : count + WIDTH'(1);
    end

endmodule

// File: rtl/sc_countdown_timer.sv
// sc_countdown_timer: loadable down-counting game timer with pause, bonus add and expiry flag.
module sc_countdown_timer
    import sc_countdown_timer_pkg::*;
#(
    parameter int                   DATAWIDTH   = DATAWIDTH_DEF,
    parameter logic [DATAWIDTH-1:0] INIT_VALUE  = DATAWIDTH'(INIT_VALUE_DEF),
    parameter logic [DATAWIDTH-1:0] ADD_VALUE   = DATAWIDTH'(ADD_VALUE_DEF),
    parameter int                   PRESC_WIDTH = PRESC_WIDTH_DEF,
    parameter int                   PRESC_MAX   = PRESC_MAX_DEF
) (
    input  logic                 SC_countdown_timer_CLOCK_50,
    input  logic                 SC_countdown_timer_RESET_InHigh,
    input  logic                 SC_countdown_timer_load_InLow,
    input  logic [DATAWIDTH-1:0] SC_countdown_timer_data_InBUS,
    input  logic                 SC_countdown_timer_start_InLow,
    input  logic                 SC_countdown_timer_pause_InLow,
    input  logic                 SC_countdown_timer_addtime_InLow,
    output logic [DATAWIDTH-1:0] SC_countdown_timer_data_OutBUS,
    output logic                 SC_countdown_timer_tick_Out,
    output logic                 SC_countdown_timer_expired_OutHigh,
    output logic [1:0]           SC_countdown_timer_state_OutBUS
);

    logic                 clk, rst, load, start, pause;
    logic                 add_q, add_ev, add_ok, en, clr, term;
    logic [PRESC_WIDTH-1:0] presc;
    logic [DATAWIDTH:0]   sum;
    logic [DATAWIDTH-1:0] count, next_count;
    state_t               state;

    assign clk   = SC_countdown_timer_CLOCK_50;
    assign rst   = SC_countdown_timer_RESET_InHigh;
    assign load  = ~SC_countdown_timer_load_InLow;
    assign start = ~SC_countdown_timer_start_InLow;
    assign pause = ~SC_countdown_timer_pause_InLow;

    // add_q idles high so a pin already low out of reset counts as a falling edge
    assign add_ev = add_q & ~SC_countdown_timer_addtime_InLow;
    assign add_ok = add_ev && !load && state != EXPIRED;
    assign en     = state == RUN && !load && !pause;
    assign clr    = load || (state == IDLE && start);

    sc_prescaler_tick #(
        .WIDTH (PRESC_WIDTH),
        .MAX   (PRESC_MAX)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (clr),
        .count (presc),
        .term  (term)
    );

    // One extra bit catches overflow; a tick only happens with count >= 1, so no underflow.
    always_comb begin
        sum        = {1'b0, count} + {1'b0, add_ok ? ADD_VALUE : '0} - {{DATAWIDTH{1'b0}}, term};
        next_count = sum[DATAWIDTH] ? '1 : sum[DATAWIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= INIT_VALUE;
            state   <= IDLE;
            add_q   <= 1'b1;
            SC_countdown_timer_tick_Out        <= 1'b0;
            SC_countdown_timer_expired_OutHigh <= 1'b0;
        end else begin
            add_q <= SC_countdown_timer_addtime_InLow;
            SC_countdown_timer_tick_Out        <= term;
            SC_countdown_timer_expired_OutHigh <= state == EXPIRED;
            if (load) begin
                count <= SC_countdown_timer_data_InBUS;
                state <= IDLE;
            end else begin
                count <= next_count;
                case (state)
                    IDLE:    if (start) state <= next_count == '0 ? EXPIRED : RUN;
                    RUN:     if (pause) state <= PAUSE;
                             else if (term && next_count == '0) state <= EXPIRED;
                    PAUSE:   if (start && !pause) state <= RUN;
                    default: state <= EXPIRED;
                endcase
            end
        end
    end

    assign SC_countdown_timer_data_OutBUS  = count;
    assign SC_countdown_timer_state_OutBUS = state;

endmodule

// File: tb/tb_sc_countdown_timer.sv
// tb_sc_countdown_timer: directed scenarios plus randomized traffic against a behavioural timer model.
module tb_sc_countdown_timer;

    localparam int PMAX = 3;
    localparam int ADDV = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_n = 1'b1, start_n = 1'b1, pause_n = 1'b1, addtime_n = 1'b1;
    logic [7:0] data = 8'd0;
    logic [7:0] dout;
    logic       tick, expired;
    logic [1:0] st;

    int         checks = 0;
    int         failures = 0;

    int         m_count, m_presc;
    logic [1:0] m_state;
    logic       m_tick, m_exp, m_addq;
    logic [11:0] obs, mdl;

    assign obs = {dout, st, tick, expired};
    assign mdl = {8'(m_count), m_state, m_tick, m_exp};

    sc_countdown_timer #(
        .DATAWIDTH   (8),
        .INIT_VALUE  (8'd99),
        .ADD_VALUE   (8'd10),
        .PRESC_WIDTH (4),
        .PRESC_MAX   (PMAX)
    ) dut (
        .SC_countdown_timer_CLOCK_50        (clk),
        .SC_countdown_timer_RESET_InHigh    (rst),
        .SC_countdown_timer_load_InLow      (load_n),
        .SC_countdown_timer_data_InBUS      (data),
        .SC_countdown_timer_start_InLow     (start_n),
        .SC_countdown_timer_pause_InLow     (pause_n),
        .SC_countdown_timer_addtime_InLow   (addtime_n),
        .SC_countdown_timer_data_OutBUS     (dout),
        .SC_countdown_timer_tick_Out        (tick),
        .SC_countdown_timer_expired_OutHigh (expired),
        .SC_countdown_timer_state_OutBUS    (st)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_count = 99; m_presc = 0; m_state = 2'b00;
        m_tick = 1'b0; m_exp = 1'b0; m_addq = 1'b1;
    endtask

    // Timer behaviour per clock: load wins, then bonus add, then the mode change.
    task automatic model_step();
        logic ld, sr, ps, ev, add, tk;
        logic [1:0] ns;
        int c;
        ld = !load_n; sr = !start_n; ps = !pause_n;
        ev = m_addq && !addtime_n;
        m_addq = addtime_n;
        m_exp = (m_state == 2'b11);
        if (ld) begin
            m_count = data; m_presc = 0; m_state = 2'b00; m_tick = 1'b0;
        end else begin
            add = ev && m_state != 2'b11;
            tk = 1'b0;
            ns = m_state;
            if (m_state == 2'b01 && !ps) begin
                if (m_presc == PMAX) begin m_presc = 0; tk = 1'b1; end
                else m_presc++;
            end
            c = m_count + (add ? ADDV : 0) - (tk ? 1 : 0);
            if (c > 255) c = 255;
            case (m_state)
                2'b00: if (sr) begin m_presc = 0; ns = (c == 0) ? 2'b11 : 2'b01; end
                2'b01: if (ps) ns = 2'b10; else if (tk && c == 0) ns = 2'b11;
                2'b10: if (sr && !ps) ns = 2'b01;
                default: ;
            endcase
            m_count = c; m_state = ns; m_tick = tk;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load_value(input logic [7:0] v);
        data = v; load_n = 1'b0; start_n = 1'b1; pause_n = 1'b1;
        step();
        load_n = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        model_reset();
        if (obs !== 12'({8'd99, 2'b00, 1'b0, 1'b0})) begin
            failures++; $display("FAIL reset_state got=%h want=%h", obs, 12'({8'd99, 2'b00, 2'b00}));
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_expiry();
        int t_state = -1, t_exp = -1, nticks = 0;
        load_value(8'd3);
        start_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (obs !== mdl) begin failures++; $display("FAIL expiry cyc=%0d got=%h want=%h", i, obs, mdl); end
            checks++;
            if (tick) nticks++;
            if (st == 2'b11 && t_state < 0) t_state = i;
            if (expired && t_exp < 0) t_exp = i;
        end
        if (nticks !== 3 || t_state !== 12 || t_exp !== 13) begin
            failures++; $display("FAIL expiry_timing got ticks=%0d st=%0d exp=%0d want 3 12 13", nticks, t_state, t_exp);
        end
        checks++;
        start_n = 1'b1;
    endtask

    task automatic test_pause();
        int n = 0;
        load_value(8'd7);
        start_n = 1'b0;
        repeat (3) step();
        start_n = 1'b1; pause_n = 1'b0;
        for (int i = 0; i < 21; i++) begin
            step();
            if (obs !== mdl || tick !== 1'b0) begin failures++; $display("FAIL pause_hold cyc=%0d got=%h want=%h", i, obs, mdl); end
            checks++;
        end
        if (dout !== 8'd7 || st !== 2'b10) begin failures++; $display("FAIL pause_frozen got=%0d/%0d want 7/2", dout, st); end
        checks++;
        pause_n = 1'b1; start_n = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            n++;
            if (obs !== mdl) begin failures++; $display("FAIL pause_resume cyc=%0d got=%h want=%h", i, obs, mdl); end
            checks++;
            if (tick) break;
        end
        if (n !== 2 || dout !== 8'd6) begin failures++; $display("FAIL resume_gap got=%0d cnt=%0d want 2 6", n, dout); end
        checks++;
        start_n = 1'b1;
    endtask

    task automatic test_saturate();
        load_value(8'd250);
        start_n = 1'b0;
        repeat (2) step();
        addtime_n = 1'b0;
        step();
        if (dout !== 8'd255) begin failures++; $display("FAIL saturate got=%0d want=255", dout); end
        checks++;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs !== mdl) begin failures++; $display("FAIL add_held cyc=%0d got=%h want=%h", i, obs, mdl); end
            checks++;
        end
        addtime_n = 1'b1; start_n = 1'b1;
        step();
    endtask

    task automatic test_add_tick();
        load_value(8'd1);
        start_n = 1'b0;
        repeat (4) step();
        addtime_n = 1'b0;
        step();
        if (dout !== 8'd10 || st !== 2'b01 || tick !== 1'b1) begin
            failures++; $display("FAIL add_with_tick got cnt=%0d st=%0d tick=%b want 10 1 1", dout, st, tick);
        end
        checks++;
        if (obs !== mdl) begin failures++; $display("FAIL add_with_tick_model got=%h want=%h", obs, mdl); end
        checks++;
        addtime_n = 1'b1; start_n = 1'b1;
        step();
    endtask

    task automatic test_expired_ops();
        load_value(8'd0);
        start_n = 1'b0;
        step();
        if (st !== 2'b11) begin failures++; $display("FAIL zero_start got st=%0d want 3", st); end
        checks++;
        step();
        if (expired !== 1'b1) begin failures++; $display("FAIL expired_flag got=%b want 1", expired); end
        checks++;
        addtime_n = 1'b0;
        step();
        if (dout !== 8'd0 || st !== 2'b11) begin failures++; $display("FAIL expired_add got cnt=%0d st=%0d want 0 3", dout, st); end
        checks++;
        addtime_n = 1'b1;
        load_value(8'd20);
        if (dout !== 8'd20 || st !== 2'b00) begin failures++; $display("FAIL expired_load got cnt=%0d st=%0d want 20 0", dout, st); end
        checks++;
        step();
        if (obs !== mdl) begin failures++; $display("FAIL expired_exit got=%h want=%h", obs, mdl); end
        checks++;
    endtask

    task automatic test_reset_midrun();
        load_value(8'd5);
        start_n = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        model_reset();
        if (obs !== 12'({8'd99, 2'b00, 2'b00})) begin failures++; $display("FAIL reset_async got=%h want=%h", obs, 12'({8'd99, 4'h0})); end
        checks++;
        @(posedge clk); #1;
        if (obs !== 12'({8'd99, 2'b00, 2'b00})) begin failures++; $display("FAIL reset_midrun got=%h want=%h", obs, 12'({8'd99, 4'h0})); end
        checks++;
        start_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            load_n = ($urandom_range(0, 29) != 0);
            case ($urandom_range(0, 3))
                0:       data = 8'd0;
                1:       data = 8'($urandom_range(1, 5));
                2:       data = 8'($urandom_range(240, 255));
                default: data = 8'($urandom_range(0, 255));
            endcase
            start_n = ($urandom_range(0, 2) != 0);
            pause_n = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 4) == 0) addtime_n = ~addtime_n;
            step();
            if (obs !== mdl) begin failures++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, mdl); end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_expiry();
        test_pause();
        test_saturate();
        test_add_tick();
        test_expired_ops();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
